// File: rtl/me_best_mv_tracker.sv
// Sequential back end of the SAD comparator tree: tracks the minimum-SAD
// candidate over one block search and decodes it into a signed motion vector.
module me_best_mv_tracker #(
  parameter int unsigned BIT_WIDTH   = 14,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned ROW_BITS    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INDEX_WIDTH-1:0] in_index,
  input  logic [BIT_WIDTH-1:0]   in_sad,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] mv_x,
  output logic [ROW_BITS-1:0]    mv_y,
  output logic [BIT_WIDTH-1:0]   out_sad,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                 state_q;
  logic [ROW_BITS-1:0]    row_q;
  logic                   first_q;
  logic [BIT_WIDTH-1:0]   best_sad_q;
  logic [INDEX_WIDTH-1:0] best_p_q;
  logic [ROW_BITS-1:0]    best_r_q;

  logic                   take;
  logic [BIT_WIDTH-1:0]   best_sad_d;
  logic [INDEX_WIDTH-1:0] best_p_d;
  logic [ROW_BITS-1:0]    best_r_d;

  // Handshake flags depend on state only, never on in_valid/out_ready.
  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);

  // Candidate best after the current beat; strict less-than keeps earlier rows on ties.
  always_comb begin
    take       = first_q | (in_sad < best_sad_q);
    best_sad_d = take ? in_sad   : best_sad_q;
    best_p_d   = take ? in_index : best_p_q;
    best_r_d   = take ? row_q    : best_r_q;
  end

  // Search FSM, running minimum and HOLD-entry decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      first_q    <= 1'b0;
      best_sad_q <= '0;
      best_p_q   <= '0;
      best_r_q   <= '0;
      mv_x       <= '0;
      mv_y       <= '0;
      out_sad    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StAccum;
            row_q   <= '0;
            first_q <= 1'b1;
          end
        end
        StAccum: begin
          if (start) begin
            // Restart: a beat presented in this cycle is dropped.
            row_q   <= '0;
            first_q <= 1'b1;
          end else if (in_valid) begin
            best_sad_q <= best_sad_d;
            best_p_q   <= best_p_d;
            best_r_q   <= best_r_d;
            first_q    <= 1'b0;
            row_q      <= row_q + 1'b1;
            if (&row_q) begin
              state_q <= StHold;
              // Subtracting half the range modulo 2^width is an MSB flip.
              mv_x    <= {~best_p_d[INDEX_WIDTH-1], best_p_d[INDEX_WIDTH-2:0]};
              mv_y    <= {~best_r_d[ROW_BITS-1], best_r_d[ROW_BITS-2:0]};
              out_sad <= best_sad_d;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            if (start) begin
              state_q <= StAccum;
              row_q   <= '0;
              first_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
